memory_island_req_mux: RTL and testbench
========================================

// Module: memory_island_req_mux
// PURPOSE
// N:1 mux for mem req/gnt ports (axi_to_mem style) in front of one memory_island_core port.
// Lets more converters share a core port than the core exposes.
// Arbitrates round-robin with optional starvation override and holds the grant stable.
// Routes in-order rvalid/rdata back to the issuing input through an outstanding-ID FIFO.
// PARAMETERS
// NumInp         4   number of input ports (>=1)
// AddrWidth      32  address width
// DataWidth      64  data width (multiple of 8); StrbWidth = DataWidth/8
// MaxOutstanding 4   ID FIFO depth = max granted requests awaiting rvalid (>=1)
// StarveLimit    0   cycles an input may wait before absolute priority; 0 disables
// PORTS
// clk_i         in   1                    clock
// rst_ni        in   1                    async reset, active low
// inp_req_i     in   NumInp               request per input
// inp_gnt_o     out  NumInp               grant per input
// inp_addr_i    in   NumInp*AddrWidth     address
// inp_we_i      in   NumInp               write enable
// inp_wdata_i   in   NumInp*DataWidth     write data
// inp_strb_i    in   NumInp*StrbWidth     byte strobes
// inp_rvalid_o  out  NumInp               response valid
// inp_rdata_o   out  NumInp*DataWidth     response data (broadcast; qualify with rvalid)
// oup_req_o     out  1                    request to core
// oup_gnt_i     in   1                    grant from core
// oup_addr_o    out  AddrWidth            selected address
// oup_we_o      out  1                    selected we
// oup_wdata_o   out  DataWidth            selected wdata
// oup_strb_o    out  StrbWidth            selected strb
// oup_rvalid_i  in   1                    core response valid (reads and writes)
// oup_rdata_i   in   DataWidth            core response data
// busy_o        out  1                    FIFO non-empty
// rsp_err_o     out  1                    sticky: rvalid received with FIFO empty
// BEHAVIOUR
// - Reset: rr pointer=0, lock clear, wait counters=0, FIFO empty, rsp_err_o=0, busy_o=0.
//   oup_req_o, inp_gnt_o and inp_rvalid_o are all 0 after reset.
// - Input protocol: req held with stable payload until gnt; handshake = req & gnt, same cycle.
// - Eligible = inp_req_i & ~fifo_full. oup_req_o = |eligible, or lock set.
// - Selection order:
//   1. lock set: locked index;
//   2. else lowest-index starved input;
//   3. else first requester at or after rr pointer, wrapping NumInp-1 -> 0.
// - oup_* payload is a combinational mux of the selected input.
//   inp_gnt_o[sel] = oup_gnt_i & oup_req_o; all other grants are 0.
// - Lock: oup_req_o=1 and oup_gnt_i=0 -> register sel. Selection stays fixed until grant.
//   A newly starved input cannot preempt a lock.
// - On handshake:
//   - rr pointer <= (sel+1) mod NumInp.
//   - Lock clears.
//   - sel is pushed to the ID FIFO.
// - Starvation (StarveLimit>0): per-input counter, saturating at StarveLimit.
//   - Increments each cycle inp_req_i=1 without a grant; clears on grant or req=0.
//   - Starved = counter == StarveLimit.
// - FIFO full (count==MaxOutstanding): no new selection, oup_req_o=0, even if a pop occurs that cycle.
//   - A lock taken before full persists.
//   - The locked request is not granted-through: inp_gnt_o stays 0 while full.
// - Response: oup_rvalid_i=1 & FIFO non-empty -> inp_rvalid_o[head]=1, then pop.
//   - Zero added latency; push and pop in the same cycle are allowed.
// - oup_rvalid_i with FIFO empty: dropped, no inp_rvalid_o; rsp_err_o <= 1 until reset.
// - Reset mid-operation: all state cleared immediately; rvalids arriving afterwards set rsp_err_o.
// - NumInp=1: arbiter degenerates to pass-through; FIFO still bounds outstanding requests.
// TESTING
// - Single in0 read, oup_gnt_i=1, core rvalid 1 cycle later -> inp_gnt_o=0001 same cycle;
//   inp_rvalid_o=0001 with rdata, busy_o 1 then 0.
// - All 4 req, gnt always 1 -> grants 0001,0010,0100,1000,0001; rr wraps correctly.
// - in2 req, oup_gnt_i=0 for 3 cycles, in0 raises req -> oup_addr_o stays in2's;
//   in2 granted first, then in0.
// - MaxOutstanding=4, no rvalid, 5 requests -> 4 grants, then oup_req_o=0;
//   one rvalid -> 5th granted the next cycle.
// - StarveLimit=3, gnt pattern favouring others, in3 waits 3 cycles -> in3 granted
//   at the next unlocked selection.
// - oup_rvalid_i pulse with FIFO empty -> no inp_rvalid_o; rsp_err_o=1 until rst_ni low.

Source files
------------

// File: rtl/memory_island_req_mux_if.sv
// Request/response bundle between N mem-style requesters, the req mux and one core port.
// The mux sits on the slave modport; requesters and the core model drive the master side.
interface memory_island_req_mux_if #(
  parameter int NumInp    = 4,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 64
);
  localparam int StrbWidth = DataWidth / 8;

  logic [NumInp-1:0]           inp_req_i;
  logic [NumInp-1:0]           inp_gnt_o;
  logic [NumInp*AddrWidth-1:0] inp_addr_i;
  logic [NumInp-1:0]           inp_we_i;
  logic [NumInp*DataWidth-1:0] inp_wdata_i;
  logic [NumInp*StrbWidth-1:0] inp_strb_i;
  logic [NumInp-1:0]           inp_rvalid_o;
  logic [NumInp*DataWidth-1:0] inp_rdata_o;

  logic                        oup_req_o;
  logic                        oup_gnt_i;
  logic [AddrWidth-1:0]        oup_addr_o;
  logic                        oup_we_o;
  logic [DataWidth-1:0]        oup_wdata_o;
  logic [StrbWidth-1:0]        oup_strb_o;
  logic                        oup_rvalid_i;
  logic [DataWidth-1:0]        oup_rdata_i;

  modport slave (
    input  inp_req_i, inp_addr_i, inp_we_i, inp_wdata_i, inp_strb_i,
           oup_gnt_i, oup_rvalid_i, oup_rdata_i,
    output inp_gnt_o, inp_rvalid_o, inp_rdata_o,
           oup_req_o, oup_addr_o, oup_we_o, oup_wdata_o, oup_strb_o
  );

  modport master (
    output inp_req_i, inp_addr_i, inp_we_i, inp_wdata_i, inp_strb_i,
           oup_gnt_i, oup_rvalid_i, oup_rdata_i,
    input  inp_gnt_o, inp_rvalid_o, inp_rdata_o,
           oup_req_o, oup_addr_o, oup_we_o, oup_wdata_o, oup_strb_o
  );
endinterface

// File: rtl/memory_island_req_mux.sv
// N:1 round-robin req/gnt mux with lock-until-grant and starvation override; zero-latency
// request path and response routing through an outstanding-ID FIFO that throttles new requests when full.

module fifo_sync #(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_vld,
  input  logic [Width-1:0] push_dat,
  input  logic             pop_vld,
  output logic [Width-1:0] head_dat,
  output logic             empty,
  output logic             full
);
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_q, rd_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop;

  assign full     = (cnt_q == CntW'(Depth));
  assign empty    = (cnt_q == '0);
  assign do_push  = push_vld & ~full;
  assign do_pop   = pop_vld & ~empty;
  assign head_dat = mem_q[rd_q];

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= push_dat;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= (wr_q == PtrW'(Depth - 1)) ? '0 : wr_q + 1'b1;
      if (do_pop)  rd_q <= (rd_q == PtrW'(Depth - 1)) ? '0 : rd_q + 1'b1;
      cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end
endmodule

module memory_island_req_mux #(
  parameter int NumInp         = 4,
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 64,
  parameter int MaxOutstanding = 4,
  parameter int StarveLimit    = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  memory_island_req_mux_if.slave bus,
  output logic                   busy_o,
  output logic                   rsp_err_o
);
  localparam int StrbWidth = DataWidth / 8;
  localparam int IdxW      = (NumInp > 1) ? $clog2(NumInp) : 1;
  localparam int SW        = (StarveLimit > 0) ? $clog2(StarveLimit + 1) : 1;

  typedef logic [IdxW-1:0] idx_t;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic                 we;
    logic [DataWidth-1:0] wdata;
    logic [StrbWidth-1:0] strb;
  } req_t;

  typedef enum logic {ST_ARB, ST_LOCK} state_e;

  state_e                     state_q, state_d;
  idx_t                       lock_idx_q, rr_ptr_q, sel, head_idx;
  req_t [NumInp-1:0]          inp_req;
  req_t                       oup;
  logic [NumInp-1:0]          eligible, starved;
  logic [NumInp-1:0][SW-1:0]  wait_cnt_q;
  logic                       fifo_full, fifo_empty, hs, rsp_vld;

  for (genvar g = 0; g < NumInp; g++) begin : g_inp
    assign inp_req[g] = '{addr:  bus.inp_addr_i[g*AddrWidth +: AddrWidth],
                          we:    bus.inp_we_i[g],
                          wdata: bus.inp_wdata_i[g*DataWidth +: DataWidth],
                          strb:  bus.inp_strb_i[g*StrbWidth +: StrbWidth]};

    // Waiting time saturates at the limit; any grant or dropped request restarts it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                                    wait_cnt_q[g] <= '0;
      else if (!bus.inp_req_i[g] || bus.inp_gnt_o[g]) wait_cnt_q[g] <= '0;
      else if (wait_cnt_q[g] != SW'(StarveLimit))     wait_cnt_q[g] <= wait_cnt_q[g] + 1'b1;
    end

    assign starved[g] = (StarveLimit > 0) && (wait_cnt_q[g] == SW'(StarveLimit));
  end

  assign eligible = bus.inp_req_i & {NumInp{~fifo_full}};

  always_comb begin : p_sel
    logic found;
    idx_t j;
    sel   = rr_ptr_q;
    found = 1'b0;
    j     = rr_ptr_q;
    if (state_q == ST_LOCK) begin
      sel   = lock_idx_q;
      found = 1'b1;
    end
    for (int i = 0; i < NumInp; i++) begin
      if (!found && starved[i] && eligible[i]) begin
        sel   = idx_t'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < NumInp; i++) begin
      if (!found && eligible[j]) begin
        sel   = j;
        found = 1'b1;
      end
      j = (j == idx_t'(NumInp - 1)) ? '0 : j + 1'b1;
    end
  end

  // A full ID FIFO blocks the port outright, even a lock taken earlier.
  assign bus.oup_req_o   = ~fifo_full & ((|eligible) | (state_q == ST_LOCK));
  assign hs              = bus.oup_req_o & bus.oup_gnt_i;
  assign oup             = inp_req[sel];
  assign bus.oup_addr_o  = oup.addr;
  assign bus.oup_we_o    = oup.we;
  assign bus.oup_wdata_o = oup.wdata;
  assign bus.oup_strb_o  = oup.strb;

  always_comb begin
    bus.inp_gnt_o      = '0;
    bus.inp_gnt_o[sel] = hs;
  end

  always_comb begin
    state_d = state_q;
    if (hs)                 state_d = ST_ARB;
    else if (bus.oup_req_o) state_d = ST_LOCK;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_ARB;
      lock_idx_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == ST_LOCK) lock_idx_q <= sel;
      if (hs) rr_ptr_q <= (sel == idx_t'(NumInp - 1)) ? '0 : sel + 1'b1;
    end
  end

  fifo_sync #(
    .Width (IdxW),
    .Depth (MaxOutstanding)
  ) u_id_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push_vld (hs),
    .push_dat (sel),
    .pop_vld  (rsp_vld),
    .head_dat (head_idx),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign rsp_vld         = bus.oup_rvalid_i & ~fifo_empty;
  assign bus.inp_rdata_o = {NumInp{bus.oup_rdata_i}};
  assign busy_o          = ~fifo_empty;

  always_comb begin
    bus.inp_rvalid_o           = '0;
    bus.inp_rvalid_o[head_idx] = rsp_vld;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                               rsp_err_o <= 1'b0;
    else if (bus.oup_rvalid_i && fifo_empty)   rsp_err_o <= 1'b1;
  end
endmodule

// File: tb/tb_memory_island_req_mux.sv
// Directed bench for memory_island_req_mux: 4 inputs, 4 outstanding, starvation limit 3.
module tb_memory_island_req_mux;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int BW = DW / 8;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  logic busy_o, rsp_err_o;
  int   total = 0;
  int   bad   = 0;

  logic [3:0] t2_gnt [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] t2_rv  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  always #5 clk_i = ~clk_i;

  memory_island_req_mux_if #(.NumInp(N), .AddrWidth(AW), .DataWidth(DW)) bus ();

  memory_island_req_mux #(
    .NumInp(N), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(4), .StarveLimit(3)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .bus       (bus),
    .busy_o    (busy_o),
    .rsp_err_o (rsp_err_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [3:0] req, input logic gnt, input logic rv, input logic [63:0] rd);
    bus.inp_req_i    = req;
    bus.oup_gnt_i    = gnt;
    bus.oup_rvalid_i = rv;
    bus.oup_rdata_i  = rd;
    #1;
  endtask

  task automatic do_reset();
    drive(4'b0000, 1'b0, 1'b0, 64'h0);
    rst_ni = 1'b0;
    #1;
    tick();
    rst_ni = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      bus.inp_addr_i[i*AW +: AW]  = 32'h1000_0000 + 32'(i) * 32'h100;
      bus.inp_we_i[i]             = (i % 2) == 1;
      bus.inp_wdata_i[i*DW +: DW] = 64'hDEAD_0000_0000_0000 | 64'(i);
      bus.inp_strb_i[i*BW +: BW]  = 8'h01 << i;
    end
    bus.inp_req_i = '0; bus.oup_gnt_i = 1'b0; bus.oup_rvalid_i = 1'b0; bus.oup_rdata_i = '0;
    #1;
    chk("rst_oup_req", bus.oup_req_o, 0);
    chk("rst_gnt", bus.inp_gnt_o, 0);
    chk("rst_rvalid", bus.inp_rvalid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", rsp_err_o, 0);
    tick(); tick();
    rst_ni = 1'b1;

    // single read from in0
    drive(4'b0001, 1'b1, 1'b0, 64'h0);
    chk("t1_gnt", bus.inp_gnt_o, 4'b0001);
    chk("t1_addr", bus.oup_addr_o, 32'h1000_0000);
    chk("t1_we", bus.oup_we_o, 0);
    chk("t1_wdata", bus.oup_wdata_o, 64'hDEAD_0000_0000_0000);
    chk("t1_strb", bus.oup_strb_o, 8'h01);
    chk("t1_busy0", busy_o, 0);
    tick();
    drive(4'b0000, 1'b1, 1'b1, 64'h0123_4567_89AB_CDEF);
    chk("t1_busy1", busy_o, 1);
    chk("t1_rvalid", bus.inp_rvalid_o, 4'b0001);
    chk("t1_rdata", bus.inp_rdata_o[63:0], 64'h0123_4567_89AB_CDEF);
    chk("t1_req_idle", bus.oup_req_o, 0);
    tick();
    drive(4'b0000, 1'b0, 1'b0, 64'h0);
    chk("t1_busy2", busy_o, 0);
    chk("t1_rvalid_off", bus.inp_rvalid_o, 0);

    // all four request, round-robin wrap
    do_reset();
    drive(4'b1111, 1'b1, 1'b0, 64'h0);
    chk("t2_gnt_first", bus.inp_gnt_o, 4'b0001);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(4'b1111, 1'b1, 1'b1, 64'h0);
      chk($sformatf("t2_gnt%0d", k), bus.inp_gnt_o, t2_gnt[k]);
      chk($sformatf("t2_rv%0d", k), bus.inp_rvalid_o, t2_rv[k]);
      tick();
    end
    drive(4'b0000, 1'b0, 1'b1, 64'h0);
    chk("t2_rv_last", bus.inp_rvalid_o, 4'b0001);
    tick();
    drive(4'b0000, 1'b0, 1'b0, 64'h0);
    chk("t2_busy", busy_o, 0);
    chk("t2_err", rsp_err_o, 0);

    // lock holds in2 while in0 arrives
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(4'b0100, 1'b0, 1'b0, 64'h0);
      chk($sformatf("t3_addr%0d", k), bus.oup_addr_o, 32'h1000_0200);
      chk($sformatf("t3_nogrant%0d", k), bus.inp_gnt_o, 0);
      tick();
    end
    drive(4'b0101, 1'b0, 1'b0, 64'h0);
    chk("t3_lock_addr", bus.oup_addr_o, 32'h1000_0200);
    chk("t3_lock_req", bus.oup_req_o, 1);
    tick();
    drive(4'b0101, 1'b1, 1'b0, 64'h0);
    chk("t3_gnt_in2", bus.inp_gnt_o, 4'b0100);
    chk("t3_wdata_in2", bus.oup_wdata_o, 64'hDEAD_0000_0000_0002);
    tick();
    drive(4'b0001, 1'b1, 1'b0, 64'h0);
    chk("t3_gnt_in0", bus.inp_gnt_o, 4'b0001);
    chk("t3_addr_in0", bus.oup_addr_o, 32'h1000_0000);
    tick();
    drive(4'b0000, 1'b0, 1'b1, 64'h0);
    chk("t3_rv_in2", bus.inp_rvalid_o, 4'b0100);
    tick();
    drive(4'b0000, 1'b0, 1'b1, 64'h0);
    chk("t3_rv_in0", bus.inp_rvalid_o, 4'b0001);
    tick();
    drive(4'b0000, 1'b0, 1'b0, 64'h0);
    chk("t3_busy", busy_o, 0);

    // outstanding limit
    for (int k = 0; k < 4; k++) begin
      drive(4'b0010, 1'b1, 1'b0, 64'h0);
      chk($sformatf("t4_gnt%0d", k), bus.inp_gnt_o, 4'b0010);
      tick();
    end
    drive(4'b0010, 1'b1, 1'b0, 64'h0);
    chk("t4_full_req", bus.oup_req_o, 0);
    chk("t4_full_gnt", bus.inp_gnt_o, 0);
    chk("t4_full_busy", busy_o, 1);
    tick();
    drive(4'b0010, 1'b1, 1'b1, 64'h0000_0000_0000_FEED);
    chk("t4_pop_rv", bus.inp_rvalid_o, 4'b0010);
    chk("t4_pop_req", bus.oup_req_o, 0);
    chk("t4_pop_gnt", bus.inp_gnt_o, 0);
    tick();
    drive(4'b0010, 1'b1, 1'b0, 64'h0);
    chk("t4_fifth_gnt", bus.inp_gnt_o, 4'b0010);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(4'b0000, 1'b0, 1'b1, 64'h0);
      chk($sformatf("t4_drain%0d", k), bus.inp_rvalid_o, 4'b0010);
      tick();
    end
    drive(4'b0000, 1'b0, 1'b0, 64'h0);
    chk("t4_busy", busy_o, 0);

    // starvation: in3 waits behind a lock on in0, then beats in1
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(4'b1001, 1'b0, 1'b0, 64'h0);
      chk($sformatf("t5_sel_in0_%0d", k), bus.oup_addr_o, 32'h1000_0000);
      tick();
    end
    drive(4'b1001, 1'b1, 1'b0, 64'h0);
    chk("t5_lock_wins", bus.inp_gnt_o, 4'b0001);
    tick();
    drive(4'b1010, 1'b1, 1'b0, 64'h0);
    chk("t5_starved_gnt", bus.inp_gnt_o, 4'b1000);
    chk("t5_starved_addr", bus.oup_addr_o, 32'h1000_0300);
    tick();
    drive(4'b0010, 1'b1, 1'b0, 64'h0);
    chk("t5_in1_gnt", bus.inp_gnt_o, 4'b0010);
    tick();
    drive(4'b0000, 1'b0, 1'b1, 64'h0);
    chk("t5_rv0", bus.inp_rvalid_o, 4'b0001);
    tick();
    drive(4'b0000, 1'b0, 1'b1, 64'h0);
    chk("t5_rv3", bus.inp_rvalid_o, 4'b1000);
    tick();
    drive(4'b0000, 1'b0, 1'b1, 64'h0);
    chk("t5_rv1", bus.inp_rvalid_o, 4'b0010);
    tick();

    // stray response and reset mid-operation
    drive(4'b0000, 1'b0, 1'b1, 64'h55);
    chk("t6_no_rv", bus.inp_rvalid_o, 0);
    chk("t6_err_pre", rsp_err_o, 0);
    tick();
    drive(4'b0000, 1'b0, 1'b0, 64'h0);
    chk("t6_err_set", rsp_err_o, 1);
    tick();
    chk("t6_err_sticky", rsp_err_o, 1);
    drive(4'b0001, 1'b1, 1'b0, 64'h0);
    tick();
    drive(4'b0000, 1'b0, 1'b0, 64'h0);
    chk("t6_busy_pre_rst", busy_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("t6_busy_rst", busy_o, 0);
    chk("t6_err_rst", rsp_err_o, 0);
    tick();
    rst_ni = 1'b1;
    drive(4'b0000, 1'b0, 1'b1, 64'h0);
    chk("t6_late_rv", bus.inp_rvalid_o, 0);
    tick();
    drive(4'b0000, 1'b0, 1'b0, 64'h0);
    chk("t6_late_err", rsp_err_o, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
